calc_sram: RTL and testbench

Dual-bank (A/B) synchronous SRAM model that answers the calculator controller's memory traffic: registered reads, split writes, and a testbench-only initialize port for preloading. Bank A holds the low half and bank B the high half of each 2*DataSize word. The block sits between the calculator controller and the testbench in the calculator environment. It adds range checking and access counters so the bench can check traffic without scanning the memory arrays.

---
 rtl/calc_sram_if.sv | 32 +++
 rtl/calc_sram.sv | 82 ++++++++
 tb/tb_calc_sram.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/calc_sram_if.sv
// Memory-traffic bundle between the calculator controller (master) and calc_sram (slave).
interface calc_sram_if #(
  parameter int DataSize = 16,
  parameter int AddrSize = 8
);
  logic                  rd_en;
  logic [AddrSize-1:0]   curr_rd_addr;
  logic                  wr_en;
  logic [AddrSize-1:0]   curr_wr_addr;
  logic [2*DataSize-1:0] wr_data;
  logic                  initialize;
  logic [AddrSize-1:0]   initialize_addr;
  logic [DataSize-1:0]   initialize_data;
  logic                  initialize_loc_sel;
  logic [2*DataSize-1:0] rd_data;
  logic                  rd_valid;
  logic                  err;
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;

  modport master (
    output rd_en, curr_rd_addr, wr_en, curr_wr_addr, wr_data,
           initialize, initialize_addr, initialize_data, initialize_loc_sel,
    input  rd_data, rd_valid, err, rd_count, wr_count
  );

  modport slave (
    input  rd_en, curr_rd_addr, wr_en, curr_wr_addr, wr_data,
           initialize, initialize_addr, initialize_data, initialize_loc_sel,
    output rd_data, rd_valid, err, rd_count, wr_count
  );
endinterface

// File: rtl/calc_sram.sv
// Dual-bank (A = low half, B = high half) SRAM model with registered reads,
// write-first bypass, preload port, sticky range error and saturating access counters.
module calc_sram #(
  parameter int DataSize = 16,
  parameter int AddrSize = 8,
  parameter int Depth    = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  calc_sram_if.slave   bus
);
  localparam logic [AddrSize:0] DEPTH_LIM = (AddrSize+1)'(Depth);

  logic [DataSize-1:0] mem_a [Depth];
  logic [DataSize-1:0] mem_b [Depth];

  logic rd_ok, wr_ok, init_ok;
  logic rd_acc, wr_acc;
  logic collide;
  logic err_set;

  assign rd_ok   = {1'b0, bus.curr_rd_addr}    < DEPTH_LIM;
  assign wr_ok   = {1'b0, bus.curr_wr_addr}    < DEPTH_LIM;
  assign init_ok = {1'b0, bus.initialize_addr} < DEPTH_LIM;

  // Preload owns the cycle: reads and writes are neither performed nor counted.
  assign rd_acc = bus.rd_en & ~bus.initialize;
  assign wr_acc = bus.wr_en & ~bus.initialize;

  // Same in-range address read and written together returns the new write data.
  assign collide = rd_acc & wr_acc & rd_ok & (bus.curr_rd_addr == bus.curr_wr_addr);

  assign err_set = bus.initialize ? ~init_ok
                                  : ((rd_acc & ~rd_ok) | (wr_acc & ~wr_ok));

  // Memory arrays: no reset on contents; reset cycles block all writes.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (bus.initialize) begin
        if (init_ok) begin
          if (bus.initialize_loc_sel) mem_b[bus.initialize_addr] <= bus.initialize_data;
          else                        mem_a[bus.initialize_addr] <= bus.initialize_data;
        end
      end else if (bus.wr_en && wr_ok) begin
        mem_a[bus.curr_wr_addr] <= bus.wr_data[DataSize-1:0];
        mem_b[bus.curr_wr_addr] <= bus.wr_data[2*DataSize-1:DataSize];
      end
    end
  end

  // Registered read port; out-of-range reads still pulse valid with zero data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc;
      if (rd_acc) begin
        if (!rd_ok)       bus.rd_data <= '0;
        else if (collide) bus.rd_data <= bus.wr_data;
        else              bus.rd_data <= {mem_b[bus.curr_rd_addr], mem_a[bus.curr_rd_addr]};
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n)     bus.err <= 1'b0;
    else if (err_set) bus.err <= 1'b1;
  end

  // Saturating counters of accepted reads and writes, in or out of range.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_count <= '0;
      bus.wr_count <= '0;
    end else begin
      if (rd_acc && bus.rd_count != 16'hFFFF) bus.rd_count <= bus.rd_count + 16'd1;
      if (wr_acc && bus.wr_count != 16'hFFFF) bus.wr_count <= bus.wr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_calc_sram.sv
module tb_calc_sram;
  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  calc_sram_if #(.DataSize(16), .AddrSize(8)) bus ();

  calc_sram #(.DataSize(16), .AddrSize(8), .Depth(200)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en              = 1'b0;
    bus.curr_rd_addr       = '0;
    bus.wr_en              = 1'b0;
    bus.curr_wr_addr       = '0;
    bus.wr_data            = '0;
    bus.initialize         = 1'b0;
    bus.initialize_addr    = '0;
    bus.initialize_data    = '0;
    bus.initialize_loc_sel = 1'b0;
  endtask

  task automatic preload(input logic sel, input logic [7:0] addr, input logic [15:0] data);
    idle();
    bus.initialize         = 1'b1;
    bus.initialize_loc_sel = sel;
    bus.initialize_addr    = addr;
    bus.initialize_data    = data;
    tick();
  endtask

  task automatic read(input logic [7:0] addr);
    idle();
    bus.rd_en        = 1'b1;
    bus.curr_rd_addr = addr;
    tick();
  endtask

  task automatic write(input logic [7:0] addr, input logic [31:0] data);
    idle();
    bus.wr_en        = 1'b1;
    bus.curr_wr_addr = addr;
    bus.wr_data      = data;
    tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_rd_data",  bus.rd_data, 32'h0);
    check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("rst_err",      {31'b0, bus.err}, 32'h0);
    check("rst_rd_count", {16'b0, bus.rd_count}, 32'h0);
    check("rst_wr_count", {16'b0, bus.wr_count}, 32'h0);

    // preload then read
    reset_n = 1'b1;
    preload(1'b0, 8'd5, 16'h1234);
    preload(1'b1, 8'd5, 16'hABCD);
    check("init_no_valid", {31'b0, bus.rd_valid}, 32'h0);
    read(8'd5);
    check("pre_rd_data",  bus.rd_data, 32'hABCD1234);
    check("pre_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("pre_rd_count", {16'b0, bus.rd_count}, 32'd1);
    check("pre_err",      {31'b0, bus.err}, 32'h0);
    check("pre_wr_count", {16'b0, bus.wr_count}, 32'd0);

    // write then read, then prove halves land in A/B by overwriting B only
    write(8'd10, 32'hDEADBEEF);
    check("wr_wr_count", {16'b0, bus.wr_count}, 32'd1);
    check("wr_no_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("wr_hold_data", bus.rd_data, 32'hABCD1234);
    read(8'd10);
    check("wr_rd_data",  bus.rd_data, 32'hDEADBEEF);
    check("wr_rd_count", {16'b0, bus.rd_count}, 32'd2);
    preload(1'b1, 8'd10, 16'h5555);
    read(8'd10);
    check("split_rd_data", bus.rd_data, 32'h5555BEEF);

    // collision: write-first
    idle();
    bus.wr_en = 1'b1; bus.curr_wr_addr = 8'd7; bus.wr_data = 32'h000000FF;
    bus.rd_en = 1'b1; bus.curr_rd_addr = 8'd7;
    tick();
    check("col_rd_data",  bus.rd_data, 32'h000000FF);
    check("col_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("col_wr_count", {16'b0, bus.wr_count}, 32'd2);
    check("col_rd_count", {16'b0, bus.rd_count}, 32'd4);
    idle();
    tick();
    check("idle_no_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("idle_hold",     bus.rd_data, 32'h000000FF);

    // back-to-back reads stay valid, data in order
    read(8'd5);
    check("b2b0_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("b2b0_data",  bus.rd_data, 32'hABCD1234);
    read(8'd10);
    check("b2b1_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("b2b1_data",  bus.rd_data, 32'h5555BEEF);

    // out of range
    read(8'd200);
    check("oor_rd_valid", {31'b0, bus.rd_valid}, 32'h1);
    check("oor_rd_data",  bus.rd_data, 32'h0);
    check("oor_err",      {31'b0, bus.err}, 32'h1);
    check("oor_rd_count", {16'b0, bus.rd_count}, 32'd7);
    write(8'd250, 32'h12345678);
    check("oor_wr_err",   {31'b0, bus.err}, 32'h1);
    check("oor_wr_count", {16'b0, bus.wr_count}, 32'd3);
    read(8'd7);
    check("oor_after_rd", bus.rd_data, 32'h000000FF);
    check("oor_err_held", {31'b0, bus.err}, 32'h1);

    // initialize priority over write and read
    preload(1'b0, 8'd3, 16'h0303);
    idle();
    bus.initialize = 1'b1; bus.initialize_loc_sel = 1'b1;
    bus.initialize_addr = 8'd3; bus.initialize_data = 16'h5555;
    bus.wr_en = 1'b1; bus.curr_wr_addr = 8'd3; bus.wr_data = 32'hFFFFFFFF;
    bus.rd_en = 1'b1; bus.curr_rd_addr = 8'd3;
    tick();
    check("pri_no_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("pri_wr_count", {16'b0, bus.wr_count}, 32'd3);
    check("pri_rd_count", {16'b0, bus.rd_count}, 32'd8);
    read(8'd3);
    check("pri_rd_data",  bus.rd_data, 32'h55550303);

    // reset mid-operation
    idle();
    bus.rd_en = 1'b1; bus.curr_rd_addr = 8'd5;
    tick();
    idle();
    reset_n = 1'b0;
    tick();
    check("mrst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    check("mrst_rd_data",  bus.rd_data, 32'h0);
    check("mrst_err",      {31'b0, bus.err}, 32'h0);
    check("mrst_rd_count", {16'b0, bus.rd_count}, 32'd0);
    check("mrst_wr_count", {16'b0, bus.wr_count}, 32'd0);
    reset_n = 1'b1;
    read(8'd5);
    check("mrst_keep_mem", bus.rd_data, 32'hABCD1234);
    check("mrst_rd_cnt1",  {16'b0, bus.rd_count}, 32'd1);

    // out-of-range preload sets err and writes nothing
    preload(1'b0, 8'd201, 16'h7777);
    check("init_oor_err", {31'b0, bus.err}, 32'h1);
    check("init_oor_cnt", {16'b0, bus.rd_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
